// File: rtl/rv32i_timer_target.sv
// rv32i_timer_target
//   Memory-mapped timer target on the 16-bit rv32i memory port. It holds a 32-bit machine
//   timer, a 32-bit compare register with a level interrupt, and a scratch register. Each
//   accepted request completes with a one-cycle ready_o pulse, LATENCY cycles after acceptance.
//
//   Ports:
//     clk_i            clock, rising edge
//     reset_i          asynchronous, active-high reset
//     select_i         region strobe from the address decoder
//     read_i/write_i   request type, qualified by select_i
//     addr_i           byte address within the region (bit 0 ignored)
//     data_i           write data
//     data_o           read data; valid while ready_o=1, held afterwards
//     ready_o          one-cycle completion pulse
//     illegal_access_o pulses with ready_o on an undefined address or read+write request
//     irq_o            timer interrupt level (pending & irq enable)
//
//   Register map (byte address): 0x0 TIME_L, 0x2 TIME_H (snapshot taken at TIME_L accept),
//   0x4 CMP_L, 0x6 CMP_H, 0x8 CTRL {pending(W1C), irq_en, timer_en}, 0xA SCRATCH.
//
//   Optional feature: define RV32I_TIMER_PRESCALE_EN to advance the timer once every
//   PRESCALE enabled cycles instead of every cycle.

module rv32i_timer_target #(
  parameter int unsigned PORT_LEN  = 16,
  parameter int unsigned ADDR_BITS = 4,
  parameter int unsigned LATENCY   = 1,
  parameter int unsigned PRESCALE  = 8
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 select_i,
  input  logic                 read_i,
  input  logic                 write_i,
  input  logic [ADDR_BITS-1:0] addr_i,
  input  logic [PORT_LEN-1:0]  data_i,
  output logic [PORT_LEN-1:0]  data_o,
  output logic                 ready_o,
  output logic                 illegal_access_o,
  output logic                 irq_o
);

  localparam int unsigned HwW = ADDR_BITS - 1;
  localparam logic [HwW-1:0] HwTimeL   = HwW'(0);
  localparam logic [HwW-1:0] HwTimeH   = HwW'(1);
  localparam logic [HwW-1:0] HwCmpL    = HwW'(2);
  localparam logic [HwW-1:0] HwCmpH    = HwW'(3);
  localparam logic [HwW-1:0] HwCtrl    = HwW'(4);
  localparam logic [HwW-1:0] HwScratch = HwW'(5);

  if (PORT_LEN != 16 || ADDR_BITS < 4 || LATENCY < 1 || LATENCY > 15 || PRESCALE < 1)
  begin : g_bad_params
    $error("rv32i_timer_target: unsupported parameter value");
  end

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e                state_q;
  logic [3:0]            cnt_q;
  logic                  wr_q;
  logic                  bad_q;
  logic                  ready_q;
  logic [HwW-1:0]        hw_q;
  logic [PORT_LEN-1:0]   wdata_q;
  logic [PORT_LEN-1:0]   hold_q;
  logic [15:0]           snap_q;

  logic [31:0]           timer_q, timer_d;
  logic [31:0]           cmp_q, cmp_d;
  logic                  tmr_en_q, tmr_en_d;
  logic                  irq_en_q, irq_en_d;
  logic                  pend_q, pend_d;
  logic [PORT_LEN-1:0]   scratch_q, scratch_d;

  logic                  req;
  logic                  req_bad;
  logic [HwW-1:0]        req_hw;
  logic                  wr_commit;
  logic                  wr_ctrl;
  logic                  tick;
  logic [PORT_LEN-1:0]   rdata;
  logic                  unused_addr0;

  assign unused_addr0 = addr_i[0];

  assign req     = select_i & (read_i | write_i);
  assign req_hw  = addr_i[ADDR_BITS-1:1];
  assign req_bad = (read_i & write_i) | (req_hw > HwScratch);

  // Writes land on the clock edge that closes the response cycle.
  assign wr_commit = (state_q == StResp) & wr_q & ~bad_q;
  assign wr_ctrl   = wr_commit & (hw_q == HwCtrl);

`ifdef RV32I_TIMER_PRESCALE_EN
  localparam int unsigned PrescW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  logic [PrescW-1:0] presc_q, presc_d;

  assign tick = tmr_en_q & (presc_q == PrescW'(PRESCALE - 1));

  always_comb begin
    presc_d = presc_q;
    if (wr_ctrl && !wdata_q[0]) begin
      presc_d = '0;
    end else if (tmr_en_q) begin
      presc_d = tick ? '0 : presc_q + PrescW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) presc_q <= '0;
    else         presc_q <= presc_d;
  end
`else
  assign tick = tmr_en_q;
`endif

  // Read data comes from register state during the response cycle.
  always_comb begin
    rdata = '0;
    if (!bad_q) begin
      case (hw_q)
        HwTimeL:   rdata = timer_q[15:0];
        HwTimeH:   rdata = snap_q;
        HwCmpL:    rdata = cmp_q[15:0];
        HwCmpH:    rdata = cmp_q[31:16];
        HwCtrl:    rdata = {13'b0, pend_q, irq_en_q, tmr_en_q};
        HwScratch: rdata = scratch_q;
        default:   rdata = '0;
      endcase
    end
  end

  assign data_o           = ready_q ? rdata : hold_q;
  assign ready_o          = ready_q;
  assign illegal_access_o = ready_q & bad_q;
  assign irq_o            = pend_q & irq_en_q;

  always_comb begin
    timer_d   = timer_q + 32'(tick);
    cmp_d     = cmp_q;
    tmr_en_d  = tmr_en_q;
    irq_en_d  = irq_en_q;
    pend_d    = pend_q;
    scratch_d = scratch_q;
    if (wr_commit) begin
      case (hw_q)
        HwTimeL:   timer_d[15:0]  = wdata_q;
        HwTimeH:   timer_d[31:16] = wdata_q;
        HwCmpL:    cmp_d[15:0]    = wdata_q;
        HwCmpH:    cmp_d[31:16]   = wdata_q;
        HwCtrl: begin
          tmr_en_d = wdata_q[0];
          irq_en_d = wdata_q[1];
          if (wdata_q[2]) pend_d = 1'b0;
        end
        HwScratch: scratch_d = wdata_q;
        default: ;
      endcase
    end
    // Match set overrides a same-cycle clear.
    if (tmr_en_q && (timer_q == cmp_q)) pend_d = 1'b1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      timer_q   <= '0;
      cmp_q     <= '0;
      tmr_en_q  <= 1'b0;
      irq_en_q  <= 1'b0;
      pend_q    <= 1'b0;
      scratch_q <= '0;
    end else begin
      timer_q   <= timer_d;
      cmp_q     <= cmp_d;
      tmr_en_q  <= tmr_en_d;
      irq_en_q  <= irq_en_d;
      pend_q    <= pend_d;
      scratch_q <= scratch_d;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      bad_q   <= 1'b0;
      ready_q <= 1'b0;
      hw_q    <= '0;
      wdata_q <= '0;
      hold_q  <= '0;
      snap_q  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req) begin
            wr_q    <= write_i;
            bad_q   <= req_bad;
            hw_q    <= req_hw;
            wdata_q <= data_i;
            cnt_q   <= 4'(LATENCY - 1);
            // TIME_H reads return the upper half as it stood when TIME_L was accepted.
            if (!req_bad && (req_hw == HwTimeL)) snap_q <= timer_q[31:16];
            if (LATENCY == 1) begin
              state_q <= StResp;
              ready_q <= 1'b1;
            end else begin
              state_q <= StWait;
            end
          end
        end
        StWait: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= StResp;
            ready_q <= 1'b1;
          end
        end
        StResp: begin
          ready_q <= 1'b0;
          hold_q  <= rdata;
          state_q <= StIdle;
        end
        default: begin
          ready_q <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
